// File: rtl/rr_lane_arbiter_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin lane arbiter.
package rr_lane_arbiter_pkg;

    localparam int unsigned DEF_N        = 8;
    localparam int unsigned DEF_MAX_HOLD = 16;
    localparam int unsigned MAX_LANES    = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Wide result; callers truncate to their lane count.
    function automatic logic [MAX_LANES-1:0] onehot(input int unsigned idx);
        return {{(MAX_LANES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_lane_arbiter_pick.sv
// Combinational rotate-priority finder: first set bit of req & ~mask, searching upward from ptr.
module rr_pick
    import rr_lane_arbiter_pkg::*;
#(
    parameter int unsigned N   = DEF_N,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           found
);

    logic [N-1:0] cand;

    always_comb begin
        int unsigned idx;
        cand   = req & ~mask;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_lane_arbiter.sv
// Round-robin arbiter for one shared response lane among N requesters.
// Optional grant-tenure timeout enabled by defining RR_LANE_ARBITER_TIMEOUT_EN.
module rr_lane_arbiter
    import rr_lane_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
    parameter int unsigned IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout_err
);

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 2");
    end

    arb_state_e     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] ptr_next;
    logic [N-1:0]   win_vec;
    logic           found;
    logic           timeout_hit;
    logic           release_now;

    // gnt is zero in IDLE and the owner's one-hot in BUSY, so it doubles as the owner mask.
    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .mask   (gnt),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        win_vec     = N'(onehot(32'(winner)));
        ptr_next    = IDW'((32'(winner) + 32'd1) % N);
        release_now = done || !req[gnt_id] || timeout_hit;
    end

    assign gnt_vld = |gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= win_vec;
                        gnt_id <= winner;
                        ptr    <= ptr_next;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        if (found) begin
                            gnt    <= win_vec;
                            gnt_id <= winner;
                            ptr    <= ptr_next;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_LANE_ARBITER_TIMEOUT_EN
    localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

    logic [HCW-1:0] hold_cnt;
    logic           new_grant;

    assign timeout_hit = (state == BUSY) && (hold_cnt == HCW'(MAX_HOLD - 1));
    assign new_grant   = found && ((state == IDLE) || release_now);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Flag only revocations that nothing else would have caused.
            timeout_err <= timeout_hit && !done && req[gnt_id];
            if (new_grant) begin
                hold_cnt <= '0;
            end else if (state == BUSY && hold_cnt != HCW'(MAX_HOLD)) begin
                hold_cnt <= hold_cnt + HCW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/rr_lane_arbiter.md
Name: rr_lane_arbiter

Overview:
- Round-robin arbiter granting one shared 8-bit response lane to one of N requesters at a time.
- Drives the y-side grant vector from the x-side request vector.
- Guarantees req[i] |=> gnt[i] for an uncontested requester when the arbiter is idle.
- Holds each grant until the owner signals done, drops its request, or (optionally) times out.

Parameters:
- N, 8, number of requesters / lanes.
- MAX_HOLD, 16, maximum grant tenure in cycles (used only with the timeout feature).
- IDW, $clog2(N), width of the granted-index output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector, one bit per requester, level-sensitive.
- done  input  1  owner's release pulse; ignored when no grant is active.
- gnt  output  N  one-hot grant vector, registered.
- gnt_vld  output  1  high when any gnt bit is high.
- gnt_id  output  IDW  index of the current owner; holds its last value when gnt_vld=0.
- timeout_err  output  1  one-cycle pulse on forced revocation.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - gnt=0, gnt_vld=0, gnt_id=0, timeout_err=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- States:
  - IDLE: no owner.
  - BUSY: one owner.
- Arbitration:
  - Search req starting at index ptr, wrapping modulo N.
  - The first set bit wins.
  - Result is registered, so grant appears one cycle after the qualifying edge.
- IDLE transitions:
  - If req!=0: gnt <= onehot(winner), gnt_id <= winner, ptr <= (winner+1) mod N, state <= BUSY.
  - Otherwise stay in IDLE.
- BUSY release condition:
  - done=1, OR req[gnt_id]=0, OR timeout (if enabled).
- BUSY transitions on release:
  - Re-arbitrate in the same edge over req with the owner's bit masked.
  - If another winner exists, hand over directly: gnt switches one-hot to one-hot with no idle cycle, ptr advances past the new winner, state stays BUSY.
  - If no other winner exists, gnt <= 0, state <= IDLE.
  - The released owner is not regranted on the release edge, even if its req is still high.
- BUSY without release:
  - gnt holds.
  - New requests are queued implicitly as held-high req bits; the arbiter has no storage.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_vld = |gnt.
  - gnt never changes except on a release or reset.
- hold_cnt:
  - Clears on every new grant.
  - Increments each BUSY cycle, saturating at MAX_HOLD.
- Simultaneous events:
  - done together with the owner dropping req counts as a single release.
  - done while IDLE is ignored.
  - A requester raising and lowering req between edges is invisible.
- Reset mid-grant: gnt drops immediately (asynchronous). The ptr restart at 0 is accepted and not treated as a fairness violation.
- Fairness: with all req held high and done pulsed each cycle, grants rotate 0,1,…,N-1,0.

Optional Feature:
- Macro: RR_LANE_ARBITER_TIMEOUT_EN.
- Defined:
  - In BUSY, when hold_cnt reaches MAX_HOLD-1 with no other release, the next edge forces a release.
  - The same handover rules apply, and timeout_err pulses for 1 cycle in the cycle the new gnt appears.
- Undefined:
  - No timeout; hold_cnt logic is omitted.
  - timeout_err is tied to 0.

Decomposition:
- Package rr_lane_arbiter_pkg:
  - Default N and MAX_HOLD constants.
  - arb_state_e enum (IDLE, BUSY).
  - Function onehot(idx).
- Sub-module rr_pick:
  - Combinational rotate-priority finder.
  - Inputs: req, mask, ptr.
  - Outputs: winner index, found flag.
  - Instantiated once; the top holds the FSM, ptr and hold_cnt registers.

Test Plan:
- Reset then req=8'h04 held → gnt=8'h04, gnt_id=2, gnt_vld=1 on the next edge; gnt=0 before that edge.
- req=8'hFF held, done pulsed every cycle → gnt sequence 01,02,04,…,80,01 with no zero cycles between grants.
- Owner 3 holds; req[5] rises; after 4 cycles owner drops req[3] → gnt goes 8'h08→8'h20 at that edge, no gap.
- req=8'h01 only, done pulsed → gnt=0 and gnt_vld=0 for one cycle, then gnt=8'h01 again.
- rst asserted mid-grant (gnt=8'h10) between edges → gnt=0 immediately; after release with req=8'h30, gnt=8'h10 (ptr reset to 0).
- With RR_LANE_ARBITER_TIMEOUT_EN, MAX_HOLD=16, req=8'h03 held, no done → owner 0 keeps the grant for 16 cycles, then gnt=8'h02 with a one-cycle timeout_err; without the macro, gnt stays 8'h01 indefinitely.
